// File: rtl/eq_band_scheduler.sv
// Per-sample band sequencer for the equalizer: shares one arithmetic core across
// NBANDS bands, capturing each band result and then triggering the summing stage.
module eq_band_scheduler #(
    parameter int NBANDS  = 3,
    parameter int BAND_W  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [NBANDS-1:0] band_mask,
    input  logic              core_done,
    input  logic              clr_err,
    output logic              core_start,
    output logic [BAND_W-1:0] band_sel,
    output logic [NBANDS-1:0] bank_we,
    output logic              mix_en,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        NEXT,
        MIX
    } state_t;

    state_t            state;
    logic [NBANDS-1:0] mask_q;
    logic [TMR_W-1:0]  timer;

    logic [NBANDS-1:0] sel_onehot;
    logic [NBANDS-1:0] remaining;
    logic              timeout_hit;

    function automatic logic [BAND_W-1:0] lowest_idx(input logic [NBANDS-1:0] m);
        lowest_idx = '0;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = BAND_W'(i);
        end
    endfunction

    assign sel_onehot  = NBANDS'(1) << band_sel;
    assign remaining   = mask_q & ~sel_onehot;
    assign timeout_hit = (state == WAIT) && !core_done && (timer == TMR_W'(1));

    // Moore decodes of the state register; bank_we follows core_done in the same cycle.
    assign core_start = (state == START);
    assign mix_en     = (state == MIX);
    assign busy       = (state != IDLE);
    assign bank_we    = ((state == WAIT) && core_done) ? sel_onehot : '0;

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking would make results depend on statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            band_sel    <= '0;
            mask_q      <= '0;
            timer       <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        mask_q <= band_mask;
                        if (band_mask == '0) begin
                            state <= MIX;
                        end else begin
                            band_sel <= lowest_idx(band_mask);
                            state    <= START;
                        end
                    end
                end
                START: begin
                    timer <= TMR_W'(TIMEOUT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done || timeout_hit) state <= NEXT;
                    else                          timer <= timer - TMR_W'(1);
                end
                NEXT: begin
                    mask_q <= remaining;
                    if (|remaining) begin
                        band_sel <= lowest_idx(remaining);
                        state    <= START;
                    end else begin
                        state <= MIX;
                    end
                end
                MIX:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // Sticky flags: a set event in the same cycle as clr_err wins.
            if (sample_valid && (state != IDLE)) overrun <= 1'b1;
            else if (clr_err)                    overrun <= 1'b0;

            if (timeout_hit)  timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Scoreboarded bench for eq_band_scheduler: a band-level timing model predicts each
// start / capture / mix event; a monitor pops and compares as the DUT produces them.
module tb_eq_band_scheduler;

    localparam int NB = 3;
    localparam int TO = 15;

    logic          clk;
    logic          reset;
    logic          sample_valid;
    logic [NB-1:0] band_mask;
    logic          core_done;
    logic          clr_err;
    logic          core_start;
    logic [1:0]    band_sel;
    logic [NB-1:0] bank_we;
    logic          mix_en;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    eq_band_scheduler #(.NBANDS(NB), .BAND_W(2), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .band_mask    (band_mask),
        .core_done    (core_done),
        .clr_err      (clr_err),
        .core_start   (core_start),
        .band_sel     (band_sel),
        .bank_we      (bank_we),
        .mix_en       (mix_en),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    typedef enum int {EV_START, EV_WE, EV_MIX} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
        int       cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   lat_cfg = 6;
    logic [3:0] silent_cfg = '0;
    int   done_at = -1;
    logic exp_ovr = 1'b0;
    logic exp_to  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pop_check(input ev_kind_t kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected event: kind %0d value %0d at cycle %0d, none expected",
                     int'(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event kind", int'(kind), int'(e.kind));
            check("event value", val, e.val);
            check("event cycle", cyc, e.cyc);
        end
    endtask

    // Core model: one-cycle done pulse lat_cfg cycles after start unless that band is silent.
    initial begin
        core_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_done = (cyc == done_at);
        end
    end

    // Monitor: compare busy every cycle and every start/capture/mix event against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
                if (core_start) begin
                    pop_check(EV_START, int'(band_sel));
                    if (!silent_cfg[band_sel]) done_at = cyc + lat_cfg;
                end
                if (bank_we != '0) pop_check(EV_WE, int'(bank_we));
                if (mix_en) pop_check(EV_MIX, 0);
            end
        end
    end

    task automatic push(input ev_kind_t kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain within budget", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_and_clear_flags();
        check("overrun", int'(overrun), int'(exp_ovr));
        check("timeout_err", int'(timeout_err), int'(exp_to));
        clr_err = 1'b1;
        next_cycle();
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
        check("overrun cleared", int'(overrun), 0);
        check("timeout_err cleared", int'(timeout_err), 0);
    endtask

    // One sample: each enabled band costs lat+2 cycles (START, lat WAIT, NEXT), or
    // TIMEOUT+2 when silent; MIX follows the last band.
    task automatic run_sample(input logic [NB-1:0] mask, input int lat,
                              input logic [NB-1:0] silent, input int ovr_off,
                              input bit with_clr);
        int t0;
        int t;
        int off;
        next_cycle();
        lat_cfg    = lat;
        silent_cfg = {1'b0, silent};
        t0 = cyc;
        t  = t0 + 1;
        for (int k = 0; k < NB; k++) begin
            if (mask[k]) begin
                push(EV_START, k, t);
                if (silent[k]) begin
                    exp_to = 1'b1;
                    t += TO + 2;
                end else begin
                    push(EV_WE, 1 << k, t + lat);
                    t += lat + 2;
                end
            end
        end
        push(EV_MIX, 0, t);
        busy_lo = t0 + 1;
        busy_hi = t;
        sample_valid = 1'b1;
        band_mask    = mask;
        next_cycle();
        sample_valid = 1'b0;
        band_mask    = NB'($urandom);
        off = (ovr_off > t - t0) ? t - t0 : ovr_off;
        if (off >= 2) begin
            while (cyc < t0 + off) next_cycle();
            sample_valid = 1'b1;
            clr_err      = with_clr;
            band_mask    = NB'($urandom);
            exp_ovr      = 1'b1;
            next_cycle();
            sample_valid = 1'b0;
            clr_err      = 1'b0;
        end
        drain(200);
        next_cycle();
        check("idle after run", int'(busy), 0);
        check_and_clear_flags();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        band_mask    = '0;
        clr_err      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset core_start", int'(core_start), 0);
        check("reset mix_en", int'(mix_en), 0);
        check("reset bank_we", int'(bank_we), 0);
        check("reset busy", int'(busy), 0);
        check("reset band_sel", int'(band_sel), 0);
        check("reset overrun", int'(overrun), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        reset = 1'b1;
        repeat (5) next_cycle();
        check("idle busy", int'(busy), 0);

        run_sample(3'b111, 6, 3'b000, 0, 1'b0);
        run_sample(3'b101, 6, 3'b000, 0, 1'b0);
        run_sample(3'b000, 6, 3'b000, 0, 1'b0);
        run_sample(3'b111, 6, 3'b010, 0, 1'b0);
        run_sample(3'b111, 15, 3'b000, 0, 1'b0);
        run_sample(3'b011, 1, 3'b000, 0, 1'b0);
        run_sample(3'b111, 6, 3'b000, 5, 1'b1);
        run_sample(3'b110, 4, 3'b000, 1000, 1'b0);

        for (int r = 0; r < 20; r++) begin
            run_sample(NB'($urandom), $urandom_range(1, 15),
                       ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0,
                       ($urandom_range(0, 2) == 0) ? $urandom_range(2, 60) : 0, 1'b0);
        end

        // Reset mid-WAIT: only the first start is seen; the late core_done must be ignored.
        begin
            int t0;
            next_cycle();
            lat_cfg    = 10;
            silent_cfg = '0;
            t0 = cyc;
            push(EV_START, 0, t0 + 1);
            busy_lo = t0 + 1;
            busy_hi = t0 + 3;
            sample_valid = 1'b1;
            band_mask    = 3'b111;
            next_cycle();
            sample_valid = 1'b0;
            while (cyc < t0 + 4) next_cycle();
            reset = 1'b0;
            #1;
            check("mid reset core_start", int'(core_start), 0);
            check("mid reset mix_en", int'(mix_en), 0);
            check("mid reset bank_we", int'(bank_we), 0);
            check("mid reset busy", int'(busy), 0);
            check("mid reset band_sel", int'(band_sel), 0);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            repeat (15) next_cycle();
            check("mid reset queue", exp_q.size(), 0);
            check("mid reset idle", int'(busy), 0);
        end

        run_sample(3'b111, 6, 3'b000, 0, 1'b0);
        repeat (20) next_cycle();
        check("final queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
